// File: rtl/game_core.sv
// rtl/game_core.sv - game FSM, physics tick, per-player doodle motion, camera scroll and score
module game_core #(
  parameter int SCR_W       = 400,
  parameter int SCR_H       = 700,
  parameter int MAX_JMP_H   = 80,
  parameter int TICK_DIV    = 100,
  parameter int NUM_PLAYERS = 2,
  parameter int X_STEP      = 4,
  parameter int Y_STEP      = 2,
  parameter int POS_W       = 16,
  parameter int SCORE_W     = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_PLAYERS-1:0]       left,
  input  logic [NUM_PLAYERS-1:0]       right,
  input  logic [NUM_PLAYERS-1:0]       collide,
  output logic [NUM_PLAYERS*POS_W-1:0] doodle_x,
  output logic [NUM_PLAYERS*POS_W-1:0] doodle_y,
  output logic [NUM_PLAYERS-1:0]       alive,
  output logic [POS_W-1:0]             view_min_y,
  output logic [SCORE_W-1:0]           score,
  output logic [1:0]                   state,
  output logic                         tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int MW    = (POS_W > SCORE_W) ? POS_W : SCORE_W;

  localparam logic [POS_W-1:0]   X_INC      = POS_W'(X_STEP);
  localparam logic [POS_W-1:0]   Y_INC      = POS_W'(Y_STEP);
  localparam logic [POS_W-1:0]   JMP_MAX    = POS_W'(MAX_JMP_H);
  localparam logic [POS_W-1:0]   HALF_H     = POS_W'(SCR_H / 2);
  localparam logic [POS_W-1:0]   WRAP_LEFT  = POS_W'(SCR_W - X_STEP);
  localparam logic [POS_W:0]     SCR_W_EXT  = (POS_W+1)'(SCR_W);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [MW-1:0]      SCORE_MAXE = MW'(SCORE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} gameState_t;
  typedef enum logic {RISE = 1'b0, FALL = 1'b1} vState_t;

  gameState_t gameState, gameNext;
  logic [CNT_W-1:0] tickCnt;
  logic loadInit;

  logic [POS_W-1:0] xPos    [NUM_PLAYERS];
  logic [POS_W-1:0] yPos    [NUM_PLAYERS];
  logic [POS_W-1:0] jumpCnt [NUM_PLAYERS];
  vState_t          vState  [NUM_PLAYERS];

  logic [POS_W-1:0] xNext   [NUM_PLAYERS];
  logic [POS_W-1:0] yNext   [NUM_PLAYERS];
  logic [POS_W-1:0] jcNext  [NUM_PLAYERS];
  vState_t          vNext   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] aliveNext;

  logic [POS_W-1:0] yMax;
  logic [MW-1:0]    yMaxExt;
  logic [MW-1:0]    scoreExt;

  function automatic logic [POS_W-1:0] initX(input int idx);
    initX = POS_W'(((idx + 1) * SCR_W) / (NUM_PLAYERS + 1));
  endfunction

  function automatic logic [POS_W-1:0] stepX(input logic [POS_W-1:0] x,
                                             input logic l, input logic r);
    logic [POS_W:0] sum;
    logic [POS_W:0] wrapped;
    sum     = {1'b0, x} + {1'b0, X_INC};
    wrapped = sum - SCR_W_EXT;
    stepX   = x;
    if (l && !r)
      stepX = (x < X_INC) ? x + WRAP_LEFT : x - X_INC;
    else if (r && !l)
      stepX = (sum >= SCR_W_EXT) ? wrapped[POS_W-1:0] : sum[POS_W-1:0];
  endfunction

  assign state    = gameState;
  assign tick     = (gameState == PLAY) && (tickCnt == CNT_W'(TICK_DIV - 1));
  assign loadInit = (gameState == OVER) && start;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : gPack
    assign doodle_x[g*POS_W +: POS_W] = xPos[g];
    assign doodle_y[g*POS_W +: POS_W] = yPos[g];
  end

  always_comb begin
    gameNext = gameState;
    case (gameState)
      IDLE:    if (start) gameNext = PLAY;
      PLAY:    if (alive == '0) gameNext = OVER;
      OVER:    if (start) gameNext = IDLE;
      default: gameNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gameState <= IDLE;
    else       gameState <= gameNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tickCnt <= '0;
    else if (gameState == IDLE && start)
      tickCnt <= '0;
    else if (gameState == PLAY)
      tickCnt <= tick ? '0 : tickCnt + CNT_W'(1);
  end

  // Death is decided before horizontal motion so a dying player freezes in place.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      xNext[i]     = xPos[i];
      yNext[i]     = yPos[i];
      jcNext[i]    = jumpCnt[i];
      vNext[i]     = vState[i];
      aliveNext[i] = alive[i];
      if (alive[i]) begin
        if (vState[i] == RISE) begin
          yNext[i]  = ({1'b0, yPos[i]} + {1'b0, Y_INC} > {1'b0, {POS_W{1'b1}}}) ?
                      {POS_W{1'b1}} : yPos[i] + Y_INC;
          jcNext[i] = jumpCnt[i] + Y_INC;
          if (jcNext[i] >= JMP_MAX) vNext[i] = FALL;
        end else if (collide[i]) begin
          vNext[i]  = RISE;
          jcNext[i] = '0;
        end else if ({1'b0, yPos[i]} < {1'b0, view_min_y} + {1'b0, Y_INC}) begin
          aliveNext[i] = 1'b0;
        end else begin
          yNext[i] = yPos[i] - Y_INC;
        end
        if (aliveNext[i]) xNext[i] = stepX(xPos[i], left[i], right[i]);
      end
    end
  end

  always_comb begin
    yMax = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (alive[i] && yPos[i] > yMax) yMax = yPos[i];
  end

  assign yMaxExt  = MW'(yMax);
  assign scoreExt = MW'(score);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || loadInit) begin
      view_min_y <= '0;
      score      <= '0;
      alive      <= '1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        xPos[i]    <= initX(i);
        yPos[i]    <= '0;
        jumpCnt[i] <= '0;
        vState[i]  <= RISE;
      end
    end else if (tick) begin
      // Camera and score follow the pre-update heights, so they trail by one tick.
      if ({1'b0, yMax} > {1'b0, view_min_y} + {1'b0, HALF_H})
        view_min_y <= yMax - HALF_H;
      if (yMaxExt > scoreExt)
        score <= (yMaxExt > SCORE_MAXE) ? SCORE_MAX : SCORE_W'(yMaxExt);
      alive <= aliveNext;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        xPos[i]    <= xNext[i];
        yPos[i]    <= yNext[i];
        jumpCnt[i] <= jcNext[i];
        vState[i]  <= vNext[i];
      end
    end
  end

endmodule
